membrane_integrator: RTL and testbench

//  Upstream stage of the activation element in each neuron column. Consumes the stream of

---
 rtl/membrane_integrator.sv | 166 ++++++++++++++++
 tb/tb_membrane_integrator.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/membrane_integrator.sv
// membrane_integrator: integrates signed synaptic currents into a wide membrane
// potential, applies a shift-based leak once per timestep and presents the
// saturated potential to the threshold element. The spike that comes back
// subtracts the threshold from the potential.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start, potential retained
// ACCUM  | accepting NUM_INPUTS current beats for this timestep
// LEAK   | single cycle: v <= v - (v >>> LEAK_SHIFT)
// OUTPUT | presenting clamped potential, waiting for mp_ready
module membrane_integrator #(
  parameter int DATA_WIDTH    = 16,
  parameter int ACC_WIDTH     = 24,
  parameter int NUM_INPUTS    = 8,
  parameter int NUM_TIMESTEPS = 4,
  parameter int LEAK_SHIFT    = 4,
  localparam int TS_W = (NUM_TIMESTEPS > 1) ? $clog2(NUM_TIMESTEPS) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_current,
  input  logic [DATA_WIDTH-1:0] threshold,
  input  logic                  spike_fb,
  output logic                  mp_valid,
  input  logic                  mp_ready,
  output logic [DATA_WIDTH-1:0] membrane_potential,
  output logic [TS_W-1:0]       timestep,
  output logic                  done
);

  localparam int CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int EXT_W = ACC_WIDTH + 1;

  localparam logic signed [EXT_W-1:0] ACC_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] ACC_MIN = {2'b11, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] DW_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] DW_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_INPUTS - 1);
  localparam logic [TS_W-1:0]  LAST_TS   = TS_W'(NUM_TIMESTEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_LEAK   = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  state_t                  state_q;
  logic signed [ACC_WIDTH-1:0] v_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [TS_W-1:0]         ts_q;
  logic                    in_ready_q;
  logic                    mp_valid_q;
  logic [DATA_WIDTH-1:0]   mp_q;
  logic                    done_q;

  logic signed [EXT_W-1:0]     sum_ext;
  logic signed [EXT_W-1:0]     sub_ext;
  logic signed [ACC_WIDTH-1:0] leak_v;

  // Saturate a one-bit-wider intermediate back into the accumulator range.
  function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic signed [EXT_W-1:0] x);
    if (x > ACC_MAX)      return ACC_MAX[ACC_WIDTH-1:0];
    else if (x < ACC_MIN) return ACC_MIN[ACC_WIDTH-1:0];
    else                  return x[ACC_WIDTH-1:0];
  endfunction

  // Clamp the wide potential into the output data range.
  function automatic logic [DATA_WIDTH-1:0] clamp_dw(input logic signed [ACC_WIDTH-1:0] x);
    if (x > DW_MAX)      return DW_MAX[DATA_WIDTH-1:0];
    else if (x < DW_MIN) return DW_MIN[DATA_WIDTH-1:0];
    else                 return x[DATA_WIDTH-1:0];
  endfunction

  // Sign-extended arithmetic one bit wider than the accumulator so overflow is visible.
  assign sum_ext = $signed({v_q[ACC_WIDTH-1], v_q})
                 + $signed({{(EXT_W-DATA_WIDTH){in_current[DATA_WIDTH-1]}}, in_current});
  assign sub_ext = $signed({v_q[ACC_WIDTH-1], v_q})
                 - $signed({{(EXT_W-DATA_WIDTH){threshold[DATA_WIDTH-1]}}, threshold});

  // Leak never overflows: the subtracted term always has the same sign as v and smaller magnitude.
  assign leak_v = (LEAK_SHIFT == 0) ? v_q : v_q - (v_q >>> LEAK_SHIFT);

  // Sequencer: state, potential, counters and all registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      v_q        <= '0;
      cnt_q      <= '0;
      ts_q       <= '0;
      in_ready_q <= 1'b0;
      mp_valid_q <= 1'b0;
      mp_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        // start from any state restarts the inference without a done pulse
        state_q    <= S_ACCUM;
        v_q        <= '0;
        cnt_q      <= '0;
        ts_q       <= '0;
        in_ready_q <= 1'b1;
        mp_valid_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q <= S_IDLE;
          end
          S_ACCUM: begin
            if (in_valid && in_ready_q) begin
              v_q <= sat_acc(sum_ext);
              if (cnt_q == LAST_BEAT) begin
                cnt_q      <= '0;
                in_ready_q <= 1'b0;
                state_q    <= S_LEAK;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          S_LEAK: begin
            v_q        <= leak_v;
            mp_q       <= clamp_dw(leak_v);
            mp_valid_q <= 1'b1;
            state_q    <= S_OUTPUT;
          end
          S_OUTPUT: begin
            if (mp_ready) begin
              if (spike_fb) begin
                v_q <= sat_acc(sub_ext);
              end
              mp_valid_q <= 1'b0;
              if (ts_q == LAST_TS) begin
                ts_q    <= '0;
                done_q  <= 1'b1;
                state_q <= S_IDLE;
              end else begin
                ts_q       <= ts_q + TS_W'(1);
                in_ready_q <= 1'b1;
                state_q    <= S_ACCUM;
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign in_ready           = in_ready_q;
  assign mp_valid           = mp_valid_q;
  assign membrane_potential = mp_q;
  assign timestep           = ts_q;
  assign done               = done_q;

endmodule

// File: tb/tb_membrane_integrator.sv
// Bench for membrane_integrator: two instances (leak off, leak shift 2) share one
// stimulus stream; directed table, hand sequences, then randomized inferences
// checked against an arithmetic model.
module tb_membrane_integrator;

  localparam int NI = 4;
  localparam int NT = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        mp_ready = 1'b0;
  logic        spike_fb = 1'b0;
  logic [15:0] in_current = '0;
  logic [15:0] threshold = '0;

  logic        in_ready0, in_ready2, mp_valid0, mp_valid2, done0, done2;
  logic [15:0] mp0, mp2;
  logic [0:0]  ts0, ts2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  membrane_integrator #(.DATA_WIDTH(16), .ACC_WIDTH(24), .NUM_INPUTS(NI),
                        .NUM_TIMESTEPS(NT), .LEAK_SHIFT(0)) u_ls0 (
    .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_ready(in_ready0),
    .in_current(in_current), .threshold(threshold), .spike_fb(spike_fb),
    .mp_valid(mp_valid0), .mp_ready(mp_ready), .membrane_potential(mp0),
    .timestep(ts0), .done(done0));

  membrane_integrator #(.DATA_WIDTH(16), .ACC_WIDTH(24), .NUM_INPUTS(NI),
                        .NUM_TIMESTEPS(NT), .LEAK_SHIFT(2)) u_ls2 (
    .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
    .in_current(in_current), .threshold(threshold), .spike_fb(spike_fb),
    .mp_valid(mp_valid2), .mp_ready(mp_ready), .membrane_potential(mp2),
    .timestep(ts2), .done(done2));

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference arithmetic
  function automatic longint sat_acc(input longint x);
    if (x > 64'sd8388607)  return 64'sd8388607;
    if (x < -64'sd8388608) return -64'sd8388608;
    return x;
  endfunction

  function automatic longint clamp16(input longint x);
    if (x > 64'sd32767)  return 64'sd32767;
    if (x < -64'sd32768) return -64'sd32768;
    return x;
  endfunction

  function automatic longint leak(input longint x, input int s);
    longint d;
    if (s == 0) return x;
    d = 64'sd1 <<< s;
    // floor division, which is what an arithmetic right shift means
    if (x >= 0) return x - (x / d);
    return x - ((x - d + 1) / d);
  endfunction

  function automatic int rand16();
    logic signed [15:0] r;
    r = 16'($urandom);
    return int'(r);
  endfunction

  // All tasks enter and leave at a falling edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int c, input int gap);
    int n;
    n = 0;
    in_valid = 1'b0;
    repeat (gap) begin
      in_current = 16'($urandom);
      spike_fb = 1'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_current = 16'(c);
    while (!in_ready0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_for_beat", longint'(in_ready0), 1);
    @(negedge clk);
    in_valid = 1'b0;
    spike_fb = 1'b0;
  endtask

  task automatic do_output(input int bp, input bit spk, input int thr,
                           input longint e0, input longint e2, input int ets,
                           output int lat);
    int n;
    n = 0;
    check("in_ready_leak", longint'(in_ready0), 0);
    while (!mp_valid0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    check("mp_valid0", longint'(mp_valid0), 1);
    check("mp_valid2", longint'(mp_valid2), 1);
    check("mp_ls0", longint'($signed(mp0)), e0);
    check("mp_ls2", longint'($signed(mp2)), e2);
    check("timestep", longint'(ts0), longint'(ets));
    check("in_ready_out", longint'(in_ready2), 0);
    repeat (bp) begin
      spike_fb = 1'($urandom);
      threshold = 16'($urandom);
      @(negedge clk);
      check("bp_mp_hold", longint'($signed(mp0)), e0);
      check("bp_mp_valid", longint'(mp_valid2), 1);
      check("bp_in_ready", longint'(in_ready0), 0);
      check("bp_timestep", longint'(ts2), longint'(ets));
    end
    mp_ready = 1'b1;
    spike_fb = spk;
    threshold = 16'(thr);
    @(negedge clk);
    mp_ready = 1'b0;
    spike_fb = 1'b0;
    threshold = 16'($urandom);
    check("mp_valid_drop", longint'(mp_valid0), 0);
    check("done0", longint'(done0), (ets == NT - 1) ? 1 : 0);
    check("done2", longint'(done2), (ets == NT - 1) ? 1 : 0);
    if (ets == NT - 1) begin
      @(negedge clk);
      check("done_one_cycle", longint'(done0), 0);
    end
  endtask

  typedef struct {
    int c [4];
    bit first;
    bit spk;
    int thr;
    int e0;
    int e2;
  } vec_t;

  vec_t tbl [10];

  task automatic set_vec(input int i, input int a, input int b, input int c, input int d,
                         input bit first, input bit spk, input int thr,
                         input int e0, input int e2);
    tbl[i].c[0] = a; tbl[i].c[1] = b; tbl[i].c[2] = c; tbl[i].c[3] = d;
    tbl[i].first = first; tbl[i].spk = spk; tbl[i].thr = thr;
    tbl[i].e0 = e0; tbl[i].e2 = e2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    longint m0, m2;
    int c, thr;
    bit spk;

    //           currents                     first spk thr   ls0     ls2
    set_vec(0,   10,    20,    30,    40,     1, 0,    0,    100,    75);
    set_vec(1,    0,     0,     0,     0,     0, 0,    0,    100,    57);
    set_vec(2,  -10,   -20,   -30,   -40,     1, 0,    0,   -100,   -75);
    set_vec(3,    0,     0,     0,     0,     0, 0,    0,   -100,   -56);
    set_vec(4,   10,    20,    30,    40,     1, 1,   60,    100,    75);
    set_vec(5,    0,     0,     0,     5,     0, 0,    0,     45,    15);
    set_vec(6, 32767, 32767, 32767, 32767,    1, 0,    0,  32767, 32767);
    set_vec(7, -32768, -32768, -32768, -32768, 0, 0,   0,     -4, -24578);
    set_vec(8, -32768, -32768, -32768, -32768, 1, 0,   0, -32768, -32768);
    set_vec(9, 32767, 32767, 32767, 32767,    0, 1, -100,    -4,  24573);

    // reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", longint'(in_ready0), 0);
    check("rst_mp_valid", longint'(mp_valid0), 0);
    check("rst_mp", longint'(mp0), 0);
    check("rst_ts", longint'(ts0), 0);
    check("rst_done", longint'(done0), 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_in_ready", longint'(in_ready0), 0);

    // directed table
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].first) pulse_start();
      for (int b = 0; b < NI; b++) feed(tbl[i].c[b], 0);
      do_output(0, tbl[i].spk, tbl[i].thr, tbl[i].e0, tbl[i].e2, tbl[i].first ? 0 : 1, lat);
      check("latency", lat, 1);
    end

    // input gaps stall the beat count, output backpressure holds everything
    pulse_start();
    feed(1, 2); feed(2, 0); feed(3, 3); feed(4, 1);
    do_output(5, 1'b0, 0, 10, 8, 0, lat);
    for (int b = 0; b < NI; b++) feed(0, 1);
    do_output(3, 1'b0, 0, 10, 6, 1, lat);

    // asynchronous reset in the middle of timestep 1 accumulation
    pulse_start();
    for (int b = 0; b < NI; b++) feed(5, 0);
    do_output(0, 1'b0, 0, 20, 15, 0, lat);
    feed(7, 0); feed(7, 0);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_in_ready", longint'(in_ready0), 0);
    check("arst_mp", longint'(mp0), 0);
    check("arst_mp2", longint'(mp2), 0);
    check("arst_ts", longint'(ts0), 0);
    check("arst_mp_valid", longint'(mp_valid2), 0);
    check("arst_done", longint'(done0), 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_idle", longint'(in_ready0), 0);
    pulse_start();
    for (int b = 0; b < NI; b++) feed(1, 0);
    do_output(0, 1'b0, 0, 4, 3, 0, lat);
    for (int b = 0; b < NI; b++) feed(0, 0);
    do_output(0, 1'b0, 0, 4, 3, 1, lat);

    // start while presenting the last timestep aborts without done
    pulse_start();
    for (int b = 0; b < NI; b++) feed(9, 0);
    do_output(0, 1'b0, 0, 36, 27, 0, lat);
    for (int b = 0; b < NI; b++) feed(0, 0);
    @(negedge clk);
    check("abort_pre_valid", longint'(mp_valid0), 1);
    check("abort_pre_ts", longint'(ts0), 1);
    pulse_start();
    check("abort_in_ready", longint'(in_ready0), 1);
    check("abort_mp_valid", longint'(mp_valid0), 0);
    check("abort_ts", longint'(ts0), 0);
    check("abort_done", longint'(done0), 0);
    @(negedge clk);
    check("abort_done_late", longint'(done2), 0);
    feed(1, 0); feed(2, 0); feed(3, 0); feed(4, 0);
    do_output(0, 1'b0, 0, 10, 8, 0, lat);
    for (int b = 0; b < NI; b++) feed(0, 0);
    do_output(0, 1'b0, 0, 10, 6, 1, lat);

    // randomized inferences against the model
    for (int k = 0; k < 25; k++) begin
      pulse_start();
      m0 = 0;
      m2 = 0;
      for (int t = 0; t < NT; t++) begin
        for (int b = 0; b < NI; b++) begin
          case ($urandom_range(0, 3))
            0: c = 32767;
            1: c = -32768;
            default: c = rand16();
          endcase
          feed(c, $urandom_range(0, 2));
          m0 = sat_acc(m0 + c);
          m2 = sat_acc(m2 + c);
        end
        m0 = leak(m0, 0);
        m2 = leak(m2, 2);
        spk = 1'($urandom);
        thr = rand16();
        do_output($urandom_range(0, 3), spk, thr, clamp16(m0), clamp16(m2), t, lat);
        check("rand_latency", lat, 1);
        if (spk) begin
          m0 = sat_acc(m0 - thr);
          m2 = sat_acc(m2 - thr);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
